// File: rtl/rr_arbiter8.sv
// rtl/rr_arbiter8.sv - registered 8-way round-robin arbiter with sticky grants and hold-limit preemption
module rr_arbiter8 #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [7:0] req_i,
    output logic [7:0] gnt_o,
    output logic       gnt_valid_o,
    output logic [2:0] gnt_idx_o,
    output logic       preempt_o
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_e;

    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);
    localparam bit         PREEMPT_EN = (MAX_HOLD != 0);

    state_e     state_q, state_d;
    logic [7:0] gnt_q, gnt_d;
    logic       valid_q, valid_d;
    logic [2:0] idx_q, idx_d;
    logic [2:0] last_q, last_d;
    logic [7:0] hcnt_q, hcnt_d;
    logic       preempt_q, preempt_d;
    logic [7:0] next_pick;
    logic [2:0] next_idx;

    function automatic logic [7:0] lowest_set(input logic [7:0] x);
        return x & ~(x - 8'd1);
    endfunction

    function automatic logic [7:0] above_mask(input logic [2:0] k);
        logic [7:0] m;
        for (int i = 0; i < 8; i++) begin
            m[i] = (i > int'(k));
        end
        return m;
    endfunction

    // Search strictly above the last winner first; wrap to the lowest requester.
    function automatic logic [7:0] pick(input logic [7:0] req, input logic [2:0] last);
        logic [7:0] masked;
        masked = req & above_mask(last);
        return (masked != 8'd0) ? lowest_set(masked) : lowest_set(req);
    endfunction

    function automatic logic [2:0] onehot_idx(input logic [7:0] x);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (x[i]) idx = i[2:0];
        end
        return idx;
    endfunction

    assign next_idx = onehot_idx(next_pick);

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        idx_d     = idx_q;
        last_d    = last_q;
        hcnt_d    = hcnt_q;
        preempt_d = 1'b0;
        next_pick = 8'd0;
        case (state_q)
            IDLE: begin
                if (req_i != 8'd0) begin
                    next_pick = pick(req_i, last_q);
                    state_d   = GRANT;
                    gnt_d     = next_pick;
                    idx_d     = next_idx;
                    last_d    = next_idx;
                    hcnt_d    = 8'd1;
                end
            end
            GRANT: begin
                if ((req_i & gnt_q) == 8'd0) begin
                    next_pick = pick(req_i, idx_q);
                    gnt_d     = next_pick;
                    if (next_pick != 8'd0) begin
                        idx_d  = next_idx;
                        last_d = next_idx;
                        hcnt_d = 8'd1;
                    end else begin
                        state_d = IDLE;
                        hcnt_d  = 8'd0;
                    end
                end else if (PREEMPT_EN && hcnt_q == HOLD_LIMIT && (req_i & ~gnt_q) != 8'd0) begin
                    next_pick = pick(req_i & ~gnt_q, idx_q);
                    gnt_d     = next_pick;
                    idx_d     = next_idx;
                    last_d    = next_idx;
                    hcnt_d    = 8'd1;
                    preempt_d = 1'b1;
                end else if (hcnt_q != 8'hFF) begin
                    hcnt_d = hcnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        valid_d = |gnt_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            gnt_q     <= 8'd0;
            valid_q   <= 1'b0;
            idx_q     <= 3'd0;
            last_q    <= 3'd7;
            hcnt_q    <= 8'd0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            valid_q   <= valid_d;
            idx_q     <= idx_d;
            last_q    <= last_d;
            hcnt_q    <= hcnt_d;
            preempt_q <= preempt_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign gnt_valid_o = valid_q;
    assign gnt_idx_o   = idx_q;
    assign preempt_o   = preempt_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb/tb_rr_arbiter8.sv - directed scoreboard bench for rr_arbiter8 with MAX_HOLD=4
module tb_rr_arbiter8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = 8'd0;
    logic [7:0] gnt;
    logic       gnt_valid;
    logic [2:0] gnt_idx;
    logic       preempt;

    int checks = 0;
    int errors = 0;

    // Packed as {gnt, valid, idx, preempt}
    logic [12:0] exp_q[$];

    rr_arbiter8 #(.MAX_HOLD(4)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .req_i      (req),
        .gnt_o      (gnt),
        .gnt_valid_o(gnt_valid),
        .gnt_idx_o  (gnt_idx),
        .preempt_o  (preempt)
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] pack(input logic [7:0] g, input logic [2:0] i, input logic p);
        return {g, (g != 8'd0), i, p};
    endfunction

    task automatic check(input string tag, input logic [12:0] exp);
        logic [12:0] obs;
        obs = {gnt, gnt_valid, gnt_idx, preempt};
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got gnt=%h valid=%b idx=%0d pre=%b, expected gnt=%h valid=%b idx=%0d pre=%b",
                   tag, obs[12:5], obs[4], obs[3:1], obs[0], exp[12:5], exp[4], exp[3:1], exp[0]);
        end
    endtask

    // Drive req for one edge; outputs sampled at the following falling edge.
    task automatic step(input string tag, input logic [7:0] r,
                        input logic [7:0] eg, input logic [2:0] ei, input logic ep);
        req = r;
        exp_q.push_back(pack(eg, ei, ep));
        @(negedge clk);
        check(tag, exp_q.pop_front());
    endtask

    task automatic do_reset();
        @(negedge clk);
        req   = 8'd0;
        rst_n = 1'b0;
        @(negedge clk);
        check("reset_state", pack(8'd0, 3'd0, 1'b0));
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset and idle
        #1;
        check("reset_async", pack(8'd0, 3'd0, 1'b0));
        do_reset();
        for (int i = 0; i < 10; i++) step("idle", 8'h00, 8'h00, 3'd0, 1'b0);

        // Single request held for five edges then released
        for (int i = 0; i < 5; i++) step("single_hold", 8'h08, 8'h08, 3'd3, 1'b0);
        step("single_release", 8'h00, 8'h00, 3'd3, 1'b0);
        step("single_idle", 8'h00, 8'h00, 3'd3, 1'b0);

        // Release hand-off without bubble, then wrap from 6 back to 0
        do_reset();
        step("handoff_first", 8'h41, 8'h01, 3'd0, 1'b0);
        step("handoff_hold", 8'h41, 8'h01, 3'd0, 1'b0);
        step("handoff_to6", 8'h40, 8'h40, 3'd6, 1'b0);
        step("handoff_hold6", 8'h40, 8'h40, 3'd6, 1'b0);
        step("wrap_to0", 8'h01, 8'h01, 3'd0, 1'b0);
        step("wrap_idle", 8'h00, 8'h00, 3'd0, 1'b0);

        // Full contention: each grant visible for exactly four cycles
        do_reset();
        for (int k = 0; k < 9; k++) begin
            for (int c = 0; c < 4; c++) begin
                step("rotate", 8'hFF, 8'(1 << (k % 8)), 3'(k % 8), (c == 0) && (k != 0));
            end
        end
        step("rotate_release", 8'h00, 8'h00, 3'd0, 1'b0);

        // Lone requester: counter must saturate, so later contention never reaches the limit
        do_reset();
        for (int i = 0; i < 300; i++) step("solo_hold", 8'h10, 8'h10, 3'd4, 1'b0);
        for (int i = 0; i < 230; i++) step("solo_saturated", 8'h11, 8'h10, 3'd4, 1'b0);
        step("solo_release_wrap", 8'h01, 8'h01, 3'd0, 1'b0);

        // Asynchronous reset between edges while bit 2 holds the grant
        do_reset();
        step("async_grant", 8'h04, 8'h04, 3'd2, 1'b0);
        step("async_hold", 8'h04, 8'h04, 3'd2, 1'b0);
        #1 rst_n = 1'b0;
        #1 check("async_clear", pack(8'd0, 3'd0, 1'b0));
        #1 rst_n = 1'b1;
        step("restart_bit0_search", 8'h14, 8'h04, 3'd2, 1'b0);
        for (int i = 0; i < 3; i++) step("restart_hold", 8'h14, 8'h04, 3'd2, 1'b0);
        step("restart_preempt", 8'h14, 8'h10, 3'd4, 1'b1);
        step("restart_pulse_once", 8'h14, 8'h10, 3'd4, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_arbiter8.md
# rr_arbiter8

Registered round-robin arbiter for 8 requesters sharing a single resource, e.g. a shared adder or bus port. It is built around the same isolate-lowest-set-bit primitive, x & ~(x-1), as the fixed-priority arbiter, applied to a rotating-masked request vector. Grants are one-hot and sticky: a requester keeps the grant while it holds REQ. An optional hold limit preempts long holders when others are waiting. It sits between requesting engines and the shared datapath's input mux, and drives the mux select.

## Interface
- MAX_HOLD, default 16: maximum consecutive grant cycles before preemption, legal 0..255; 0 disables preemption.
- CLK  in  1  rising-edge clock.
- RESETN  in  1  asynchronous, active-low reset.
- REQ  in  8  request vector; bit i = requester i; level-sensitive; held high for the whole transaction.
- GNT  out  8  registered one-hot grant, or all-zero.
- GNT_VALID  out  1  registered; equals |GNT.
- GNT_IDX  out  3  registered binary index of the granted bit; holds its last value when GNT_VALID=0.
- PREEMPT  out  1  registered one-cycle pulse, high in the first cycle of a grant that was produced by preemption.

## Operation
- State: IDLE (GNT=0) and GRANT (GNT one-hot). Also LAST[2:0], the most recently granted index, and HCNT[7:0], the number of cycles the current grant has been visible.
- Pick function:
  - M = REQ & mask(LAST), where mask(k) = bits strictly above k.
  - P = lowest set bit of M if M≠0, else lowest set bit of REQ.
  - P = 0 if REQ = 0.
  - Pick is combinational; every output is taken from registers.
- IDLE:
  - If REQ ≠ 0: go to GRANT; GNT←P; LAST←idx(P); HCNT←1.
  - Else stay in IDLE.
- GRANT, with g = granted index, evaluated every edge in priority order:
  - Release, REQ[g]=0: re-pick with LAST=g.
    - If P≠0: GNT←P; HCNT←1; stay in GRANT. There is no idle bubble.
    - If P=0: GNT←0; go to IDLE.
  - Preempt, MAX_HOLD≠0, HCNT=MAX_HOLD and (REQ & ~GNT)≠0: GNT←P, with the pick excluding g; HCNT←1; PREEMPT←1.
  - Otherwise: hold GNT; HCNT←min(HCNT+1, 255).
- Pointer wrap: mask(7)=0, so the search after index 7 falls back to the lowest set bit, starting at bit 0.
- A request dropped and re-raised by a non-granted requester has no effect beyond its level at each edge. No request is latched.
- A requester that is granted for only one cycle is legal: it drops REQ in the cycle after GNT appears.

## Timing
- Reset (RESETN low, asynchronous): GNT=0, GNT_VALID=0, GNT_IDX=0, PREEMPT=0, state=IDLE, HCNT=0, LAST=7. The first arbitration therefore favours bit 0.
- Reset asserted mid-grant: all outputs clear immediately, with no clock required. After release, arbitration restarts from LAST=7.
- Grant latency:
  - REQ sampled high at edge t in IDLE gives GNT high after edge t, i.e. visible in cycle t+1.
  - On release, the new GNT is visible in the cycle after REQ[g] is sampled low.
- Hold limit: with contention, each grant is visible for exactly MAX_HOLD cycles.
- PREEMPT is high only in the first cycle of the new grant, never two cycles in a row for the same grant.
- Simultaneous release and limit reached: release wins. PREEMPT=0.
- GNT is never multi-hot and never changes except at a clock edge or on reset.

## Test plan
- Reset/idle:
  - Stimulus: RESETN low, then high with REQ=0x00 for 10 cycles.
  - Required: GNT=0x00, GNT_VALID=0, GNT_IDX=0, PREEMPT=0 throughout.
- Single request and release:
  - Stimulus: REQ=0x08 at edge 0; drop it at edge 5.
  - Required: GNT=0x08 and GNT_IDX=3 in cycles 1–5; GNT=0x00 from cycle 6.
- Release hand-off and wrap:
  - Stimulus: REQ=0x41 from reset.
  - Required: GNT=0x01.
  - Stimulus: drop bit 0.
  - Required: GNT=0x40 next cycle, with no bubble.
  - Stimulus: set REQ=0x01.
  - Required: GNT=0x01 (wrap from 6 to 0).
- Preemption rotation:
  - Stimulus: MAX_HOLD=4, REQ=0xFF held.
  - Required: grants 0x01, 0x02, …, 0x80, 0x01, each for exactly 4 cycles. PREEMPT pulses on every change except the first grant.
- No preemption without contention:
  - Stimulus: MAX_HOLD=4, REQ=0x10 for 300 cycles.
  - Required: GNT=0x10 constant, PREEMPT=0, HCNT saturates at 255 without wrapping.
- Async reset mid-grant:
  - Stimulus: RESETN pulsed low between edges while GNT=0x04.
  - Required: GNT=0x00 before the next edge. With REQ=0x14 after release, the first grant is 0x04 (search from bit 0).
